// File: rtl/ccc_lock_reset_seq_pkg.sv
// Purpose : shared state encodings and counter sizing for the CCC lock/reset sequencer.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package ccc_seq_pkg;

   // Sequencer state, kept as plain 3-bit constants so SEQ_STATE can be
   // consumed by legacy software and scripts that decode raw numbers.
   typedef logic [2:0] seq_state_t;

   localparam seq_state_t ST_OFF       = 3'd0;
   localparam seq_state_t ST_ARST      = 3'd1;
   localparam seq_state_t ST_WAIT_LOCK = 3'd2;
   localparam seq_state_t ST_RELEASE   = 3'd3;
   localparam seq_state_t ST_RUN       = 3'd4;

   // Width of the shared cycle counters: wide enough to hold the largest
   // cycle parameter itself, since the timeout compare uses the
   // post-increment value, which can equal that parameter.
   function automatic int cnt_width(input int a, input int b, input int c,
                                    input int d, input int e);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      if (m < 1) m = 1;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/ccc_lock_reset_seq_if.sv
// Purpose : pin group between the sequencer and the CCC wrapper (LOCK in, PLL control out).
// Latency : n/a (wires only).
// Backpressure : none; LOCK is level-sensitive and asynchronous to the sequencer clock.
interface ccc_lock_reset_seq_if;

   logic LOCK;             // raw PLL lock, asynchronous
   logic PLL_POWERDOWN_N;  // low = PLL powered down
   logic PLL_ARST_N;       // low = PLL held in reset

   // Sequencer side.
   modport master (
      input  LOCK,
      output PLL_POWERDOWN_N,
      output PLL_ARST_N
   );

   // CCC side.
   modport slave (
      output LOCK,
      input  PLL_POWERDOWN_N,
      input  PLL_ARST_N
   );

endinterface

// File: rtl/ccc_lock_reset_seq_ce_div.sv
// Purpose : one channel's clock-enable divider; ce pulses once every div+1 cycles while en=1.
// Latency : ce is registered; first pulse lands div cycles after the enabling edge.
// Backpressure : none. Ports: clk, rst_n, en (channel out of reset), div (divide value), ce.
module ccc_ce_div #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] div,
   output logic         ce
);

   logic [W-1:0] cnt;

   // '>=' rather than '==' so that lowering div below the current count
   // wraps on the next cycle instead of running the counter all the way round.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         ce  <= 1'b0;
      end else if (!en) begin
         cnt <= '0;
         ce  <= 1'b0;
      end else if (cnt >= div) begin
         cnt <= '0;
         ce  <= 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
         ce  <= 1'b0;
      end
   end

endmodule

// File: rtl/ccc_lock_reset_seq.sv
// Purpose : PLL power-up / lock qualification / staggered reset release for a fabric CCC.
// Latency : all outputs registered; LOCK seen through a 2-flop synchroniser (2 cycles).
// Backpressure : none; RELOCK_REQ is a single-cycle pulse honoured in every state but OFF.
// Ports   : CLK, RESET_N (async active-low); ccc (LOCK in, PLL_POWERDOWN_N/PLL_ARST_N out);
//           RELOCK_REQ, CE_DIV in; CH_RESET_N, CH_CE, READY, TIMEOUT_ERR, SEQ_STATE, LOSS_CNT out.
// Option  : define CCC_SEQ_LOSS_CNT_EN to build the saturating lock-loss counter on LOSS_CNT;
//           otherwise LOSS_CNT is tied to 0.
module ccc_lock_reset_seq
   import ccc_seq_pkg::*;
#(
   parameter int NUM_CH           = 4,
   parameter int PWRUP_CYC        = 64,
   parameter int ARST_CYC         = 16,
   parameter int LOCK_STABLE_CYC  = 256,
   parameter int LOCK_TIMEOUT_CYC = 65536,
   parameter int STAGGER_CYC      = 8,
   parameter int CE_DIV_W         = 8
) (
   input  logic                         CLK,
   input  logic                         RESET_N,
   ccc_lock_reset_seq_if.master         ccc,
   input  logic                         RELOCK_REQ,
   input  logic [NUM_CH*CE_DIV_W-1:0]   CE_DIV,
   output logic [NUM_CH-1:0]            CH_RESET_N,
   output logic [NUM_CH-1:0]            CH_CE,
   output logic                         READY,
   output logic                         TIMEOUT_ERR,
   output logic [2:0]                   SEQ_STATE,
   output logic [7:0]                   LOSS_CNT
);

   localparam int CW = cnt_width(PWRUP_CYC, ARST_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC,
                                 (NUM_CH - 1) * STAGGER_CYC);

   localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_CYC - 1);
   localparam logic [CW-1:0] ARST_LAST  = CW'(ARST_CYC - 1);
   localparam logic [CW-1:0] STABLE_N   = CW'(LOCK_STABLE_CYC);
   localparam logic [CW-1:0] TMO_N      = CW'(LOCK_TIMEOUT_CYC);
   localparam logic [CW-1:0] REL_LAST   = CW'((NUM_CH - 1) * STAGGER_CYC);

   seq_state_t          state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;     // cycles since state entry
   logic [CW-1:0]       scnt, scnt_nxt;   // consecutive LOCK_S-high cycles
   logic                lock_m, lock_s;
   logic                to_err;           // timeout this cycle
   logic                loss;             // lock-loss transition this cycle
   logic [NUM_CH-1:0]   ch_rst_nxt;

   // LOCK comes from the PLL domain: two flops before any decision uses it.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= ccc.LOCK;
         lock_s <= lock_m;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      scnt_nxt  = '0;
      to_err    = 1'b0;
      loss      = 1'b0;
      case (state)
         ST_OFF: begin
            if (cnt == PWRUP_LAST) begin
               state_nxt = ST_ARST;
               cnt_nxt   = '0;
            end
         end
         ST_ARST: begin
            if (cnt == ARST_LAST) begin
               state_nxt = ST_WAIT_LOCK;
               cnt_nxt   = '0;
            end
         end
         ST_WAIT_LOCK: begin
            scnt_nxt = lock_s ? scnt + 1'b1 : '0;
            // Lock is tested first so it wins a same-cycle tie with timeout.
            if (scnt_nxt == STABLE_N) begin
               state_nxt = ST_RELEASE;
               cnt_nxt   = '0;
            end else if (cnt_nxt == TMO_N) begin
               state_nxt = ST_OFF;
               cnt_nxt   = '0;
               to_err    = 1'b1;
            end
         end
         ST_RELEASE: begin
            if (!lock_s) begin
               loss = 1'b1;
            end else if (cnt == REL_LAST) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end
         end
         ST_RUN: begin
            cnt_nxt = cnt;
            if (!lock_s) loss = 1'b1;
         end
         default: begin
            state_nxt = ST_OFF;
            cnt_nxt   = '0;
         end
      endcase

      if (loss) begin
         state_nxt = ST_ARST;
         cnt_nxt   = '0;
      end

      // A relock request overrides every other transition, including a
      // simultaneous lock loss, so that case is not counted as a loss.
      if (RELOCK_REQ && (state != ST_OFF)) begin
         state_nxt = ST_OFF;
         cnt_nxt   = '0;
         to_err    = 1'b0;
         loss      = 1'b0;
      end
   end

   // Channel k opens once k*STAGGER_CYC cycles have elapsed in RELEASE;
   // cnt_nxt is 0 on the entry edge, so channel 0 opens right away.
   always_comb begin
      ch_rst_nxt = '0;
      if (state_nxt == ST_RUN) begin
         ch_rst_nxt = '1;
      end else if (state_nxt == ST_RELEASE) begin
         for (int k = 0; k < NUM_CH; k++) begin
            ch_rst_nxt[k] = (cnt_nxt >= CW'(k * STAGGER_CYC));
         end
      end
   end

   // Outputs are registered from the next-state decode so they change on
   // the same edge as the state they belong to.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state               <= ST_OFF;
         cnt                 <= '0;
         scnt                <= '0;
         ccc.PLL_POWERDOWN_N <= 1'b0;
         ccc.PLL_ARST_N      <= 1'b0;
         CH_RESET_N          <= '0;
         READY               <= 1'b0;
         TIMEOUT_ERR         <= 1'b0;
      end else begin
         state               <= state_nxt;
         cnt                 <= cnt_nxt;
         scnt                <= scnt_nxt;
         ccc.PLL_POWERDOWN_N <= (state_nxt != ST_OFF);
         ccc.PLL_ARST_N      <= (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_RELEASE) ||
                                (state_nxt == ST_RUN);
         CH_RESET_N          <= ch_rst_nxt;
         READY               <= (state_nxt == ST_RUN);
         if (to_err) begin
            TIMEOUT_ERR <= 1'b1;
         end else if ((state_nxt == ST_RUN) && (state != ST_RUN)) begin
            TIMEOUT_ERR <= 1'b0;
         end
      end
   end

   assign SEQ_STATE = state;

`ifdef CCC_SEQ_LOSS_CNT_EN
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         LOSS_CNT <= '0;
      end else if (loss && (LOSS_CNT != 8'hFF)) begin
         LOSS_CNT <= LOSS_CNT + 1'b1;
      end
   end
`else
   assign LOSS_CNT = '0;
`endif

   // Dividers are enabled from the next-cycle reset value so a freshly
   // released channel counts from its release edge and CE drops together
   // with its reset.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ce
      ccc_ce_div #(
         .W (CE_DIV_W)
      ) u_ce_div (
         .clk   (CLK),
         .rst_n (RESET_N),
         .en    (ch_rst_nxt[i]),
         .div   (CE_DIV[i*CE_DIV_W +: CE_DIV_W]),
         .ce    (CH_CE[i])
      );
   end

endmodule

// File: tb/tb_ccc_lock_reset_seq.sv
// Purpose : directed self-checking bench for ccc_lock_reset_seq with small cycle parameters.
// Latency : outputs sampled 1 ns after each rising CLK edge; edge count restarts at reset release.
// Backpressure : n/a. Honours CCC_SEQ_LOSS_CNT_EN for the LOSS_CNT expectations.
`timescale 1ns/1ps
module tb_ccc_lock_reset_seq;
   import ccc_seq_pkg::*;

   localparam int NUM_CH = 4;
   localparam int W      = 8;
`ifdef CCC_SEQ_LOSS_CNT_EN
   localparam bit LOSS_ON = 1'b1;
`else
   localparam bit LOSS_ON = 1'b0;
`endif

   logic                  CLK = 1'b0;
   logic                  RESET_N;
   logic                  RELOCK_REQ;
   logic [NUM_CH*W-1:0]   CE_DIV;
   logic [NUM_CH-1:0]     CH_RESET_N;
   logic [NUM_CH-1:0]     CH_CE;
   logic                  READY;
   logic                  TIMEOUT_ERR;
   logic [2:0]            SEQ_STATE;
   logic [7:0]            LOSS_CNT;

   ccc_lock_reset_seq_if ccc ();

   ccc_lock_reset_seq #(
      .NUM_CH           (NUM_CH),
      .PWRUP_CYC        (4),
      .ARST_CYC         (2),
      .LOCK_STABLE_CYC  (8),
      .LOCK_TIMEOUT_CYC (50),
      .STAGGER_CYC      (3),
      .CE_DIV_W         (W)
   ) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .ccc         (ccc.master),
      .RELOCK_REQ  (RELOCK_REQ),
      .CE_DIV      (CE_DIV),
      .CH_RESET_N  (CH_RESET_N),
      .CH_CE       (CH_CE),
      .READY       (READY),
      .TIMEOUT_ERR (TIMEOUT_ERR),
      .SEQ_STATE   (SEQ_STATE),
      .LOSS_CNT    (LOSS_CNT)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_pass = 0;
   int ecnt   = 0;
   bit glitch = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] lx(input int k);
      return LOSS_ON ? k : 0;
   endfunction

   // Advance one edge and sample 1 ns later; in glitch mode LOCK is low on
   // every fifth edge so it never stays high for 8 cycles.
   task automatic tick();
      @(posedge CLK);
      #1;
      ecnt++;
      if (glitch) ccc.LOCK = (ecnt % 5 != 0);
   endtask

   task automatic run_to(input int e);
      while (ecnt < e) tick();
   endtask

   task automatic wait_state(input logic [2:0] tgt, input int budget, output int n);
      n = 0;
      while ((SEQ_STATE != tgt) && (n < budget)) begin
         tick();
         n++;
      end
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_pd_n"},   ccc.PLL_POWERDOWN_N, 0);
      chk({pfx, "_arst_n"}, ccc.PLL_ARST_N, 0);
      chk({pfx, "_ch_rst"}, CH_RESET_N, 0);
      chk({pfx, "_ch_ce"},  CH_CE, 0);
      chk({pfx, "_ready"},  READY, 0);
      chk({pfx, "_tmo"},    TIMEOUT_ERR, 0);
      chk({pfx, "_state"},  SEQ_STATE, ST_OFF);
      chk({pfx, "_loss"},   LOSS_CNT, 0);
   endtask

   initial begin
      int n;
      int c0, c1, c2, c3, low;
      RESET_N    = 1'b0;
      RELOCK_REQ = 1'b0;
      ccc.LOCK   = 1'b0;
      CE_DIV     = {8'd3, 8'd1, 8'd0, 8'd2};
      #22;
      chk_all_zero("rst");

      // ---------------- nominal power-up ----------------
      @(negedge CLK);
      RESET_N = 1'b1;
      ecnt    = 0;
      run_to(3);
      chk("off_pd_n", ccc.PLL_POWERDOWN_N, 0);
      tick();                                   // edge 4
      chk("arst_pd_n", ccc.PLL_POWERDOWN_N, 1);
      chk("arst_state", SEQ_STATE, ST_ARST);
      tick();                                   // edge 5
      chk("arst_arst_n", ccc.PLL_ARST_N, 0);
      tick();                                   // edge 6
      chk("wl_arst_n", ccc.PLL_ARST_N, 1);
      chk("wl_state", SEQ_STATE, ST_WAIT_LOCK);
      run_to(16);
      ccc.LOCK = 1'b1;                          // lock rises 10 cycles after ARST exit
      run_to(25);
      chk("wl_hold_state", SEQ_STATE, ST_WAIT_LOCK);
      tick();                                   // edge 26
      chk("rel_state", SEQ_STATE, ST_RELEASE);
      chk("rel_ch0", CH_RESET_N, 4'b0001);
      tick(); tick();                           // edge 28
      chk("ce0_first", CH_CE, 4'b0001);
      tick();                                   // edge 29
      chk("rel_ch1", CH_RESET_N, 4'b0011);
      chk("ce1_first", CH_CE, 4'b0010);
      run_to(31);
      chk("rel_ch1_hold", CH_RESET_N, 4'b0011);
      tick();                                   // edge 32
      chk("rel_ch2", CH_RESET_N, 4'b0111);
      run_to(35);
      chk("rel_ch3", CH_RESET_N, 4'b1111);
      chk("rel_ready", READY, 0);
      tick();                                   // edge 36
      chk("run_ready", READY, 1);
      chk("run_state", SEQ_STATE, ST_RUN);
      chk("run_tmo", TIMEOUT_ERR, 0);

      // ---------------- clock enable periods ----------------
      c0 = 0; c1 = 0; c2 = 0; c3 = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         c0 += int'(CH_CE[0]);
         c1 += int'(CH_CE[1]);
         c2 += int'(CH_CE[2]);
         c3 += int'(CH_CE[3]);
      end
      chk("ce0_per3", c0, 4);
      chk("ce1_const", c1, 12);
      chk("ce2_per2", c2, 6);
      chk("ce3_per4", c3, 3);

      n = 0;
      while (!CH_CE[3] && (n < 8)) begin
         tick();
         n++;
      end
      chk("ce3_seen", CH_CE[3], 1);
      tick(); tick();                           // ch3 counter now at 2
      CE_DIV[31:24] = 8'd1;
      tick();
      chk("ce3_wrap", CH_CE[3], 1);
      tick();
      chk("ce3_d1_gap", CH_CE[3], 0);
      tick();
      chk("ce3_d1_next", CH_CE[3], 1);

      // ---------------- lock loss in RUN ----------------
      ccc.LOCK = 1'b0;
      tick(); tick();
      chk("loss_sync_state", SEQ_STATE, ST_RUN);
      tick();
      chk("loss_state", SEQ_STATE, ST_ARST);
      chk("loss_ch", CH_RESET_N, 0);
      chk("loss_ce", CH_CE, 0);
      chk("loss_ready", READY, 0);
      chk("loss_pd_n", ccc.PLL_POWERDOWN_N, 1);
      chk("loss_arst_n", ccc.PLL_ARST_N, 0);
      chk("loss_cnt1", LOSS_CNT, lx(1));
      ccc.LOCK = 1'b1;
      wait_state(ST_RELEASE, 40, n);
      chk("relock_rel_lat", n, 10);
      chk("relock_ch0", CH_RESET_N, 4'b0001);
      repeat (3) tick();
      chk("relock_ch1", CH_RESET_N, 4'b0011);
      repeat (3) tick();
      chk("relock_ch2", CH_RESET_N, 4'b0111);
      repeat (3) tick();
      chk("relock_ch3", CH_RESET_N, 4'b1111);
      tick();
      chk("relock_run", SEQ_STATE, ST_RUN);

      // ---------------- RELOCK_REQ only ----------------
      RELOCK_REQ = 1'b1;
      tick();
      RELOCK_REQ = 1'b0;
      chk("rq_state", SEQ_STATE, ST_OFF);
      chk("rq_ch", CH_RESET_N, 0);
      chk("rq_ready", READY, 0);
      low = 0;
      for (int i = 0; i < 6; i++) begin
         if (!ccc.PLL_POWERDOWN_N) low++;
         tick();
      end
      chk("rq_pd_low_cyc", low, 4);
      chk("rq_loss_same", LOSS_CNT, lx(1));
      wait_state(ST_RUN, 60, n);
      chk("rq_run_lat", n, 18);

      // ---------------- RELOCK_REQ together with lock loss ----------------
      ccc.LOCK = 1'b0;
      tick(); tick();
      chk("rqloss_pre", SEQ_STATE, ST_RUN);
      RELOCK_REQ = 1'b1;
      tick();
      RELOCK_REQ = 1'b0;
      ccc.LOCK   = 1'b1;
      chk("rqloss_state", SEQ_STATE, ST_OFF);
      chk("rqloss_pd_n", ccc.PLL_POWERDOWN_N, 0);
      chk("rqloss_ch", CH_RESET_N, 0);
      chk("rqloss_loss", LOSS_CNT, lx(1));
      wait_state(ST_RUN, 60, n);
      chk("rqloss_run_lat", n, 24);

      // ---------------- reset during RELEASE ----------------
      ccc.LOCK = 1'b0;
      repeat (3) tick();
      chk("loss2_state", SEQ_STATE, ST_ARST);
      chk("loss_cnt2", LOSS_CNT, lx(2));
      ccc.LOCK = 1'b1;
      wait_state(ST_RELEASE, 40, n);
      chk("loss2_rel_lat", n, 10);
      tick(); tick();
      chk("mid_rel_ch", CH_RESET_N, 4'b0001);
      #2;
      RESET_N = 1'b0;
      #1;
      chk_all_zero("arst");

      // ---------------- lock timeout and retry ----------------
      ccc.LOCK = 1'b0;
      glitch   = 1'b1;
      @(negedge CLK);
      RESET_N = 1'b1;
      ecnt    = 0;
      run_to(55);
      chk("tmo_pre_state", SEQ_STATE, ST_WAIT_LOCK);
      chk("tmo_pre_err", TIMEOUT_ERR, 0);
      tick();                                   // edge 56: 50 cycles in WAIT_LOCK
      chk("tmo_state", SEQ_STATE, ST_OFF);
      chk("tmo_err", TIMEOUT_ERR, 1);
      chk("tmo_pd_n", ccc.PLL_POWERDOWN_N, 0);
      glitch   = 1'b0;
      ccc.LOCK = 1'b1;
      wait_state(ST_RELEASE, 40, n);
      chk("retry_rel_lat", n, 14);
      chk("retry_err_held", TIMEOUT_ERR, 1);
      wait_state(ST_RUN, 20, n);
      chk("retry_run_lat", n, 10);
      chk("retry_err_clr", TIMEOUT_ERR, 0);
      chk("retry_ready", READY, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
